jpc_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the jpc core. Owns the program-counter register's load interface (next-PC value + enable)
//  and issues one instruction-memory request at a time. Hands fetched words to decode via valid/ready and applies

---
 rtl/jpc_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_jpc_fetch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/jpc_fetch_ctrl.sv
// Fetch sequencer for the jpc core: drives the PC register load port, keeps one
// instruction-memory request in flight and buffers the fetched word for decode.
module jpc_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_I,
    output logic [ADDR_W-1:0]  pc_next_O,
    output logic               pc_en_O,
    input  logic               redirect_I,
    input  logic [ADDR_W-1:0]  redirect_pc_I,
    output logic               imem_req_O,
    output logic [ADDR_W-1:0]  imem_addr_O,
    input  logic               imem_gnt_I,
    input  logic               imem_rvalid_I,
    input  logic [INSTR_W-1:0] imem_rdata_I,
    input  logic               imem_err_I,
    output logic               inst_valid_O,
    output logic [INSTR_W-1:0] inst_O,
    output logic [ADDR_W-1:0]  inst_pc_O,
    output logic               fetch_fault_O,
    input  logic               dec_ready_I
);

    localparam logic [2:0] BOOT = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] KILL = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [2:0]         state_d, state_q;
    logic [INSTR_W-1:0] inst_d, inst_q;
    logic [ADDR_W-1:0]  inst_pc_d, inst_pc_q;
    logic               fault_d, fault_q;
    logic               pc_en_s, imem_req_s, inst_valid_s;
    logic [ADDR_W-1:0]  pc_next_s;

    // Next-state, PC load and buffer capture decisions.
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        pc_en_s      = 1'b0;
        pc_next_s    = {ADDR_W{1'b0}};
        imem_req_s   = 1'b0;
        inst_valid_s = 1'b0;
        case (state_q)
            BOOT: begin
                pc_en_s   = 1'b1;
                pc_next_s = RESET_PC;
                state_d   = REQ;
            end
            REQ: begin
                imem_req_s = 1'b1;
                if (redirect_I) begin
                    // A granted request is already wrong-path, so its response must be drained.
                    pc_en_s   = 1'b1;
                    pc_next_s = redirect_pc_I;
                    state_d   = imem_gnt_I ? KILL : REQ;
                end else if (imem_gnt_I) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (redirect_I) begin
                    pc_en_s   = 1'b1;
                    pc_next_s = redirect_pc_I;
                    state_d   = imem_rvalid_I ? REQ : KILL;
                end else if (imem_rvalid_I) begin
                    inst_d    = imem_rdata_I;
                    inst_pc_d = pc_I;
                    fault_d   = imem_err_I;
                    pc_en_s   = 1'b1;
                    pc_next_s = pc_I + STEP;
                    state_d   = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            KILL: begin
                if (redirect_I) begin
                    pc_en_s   = 1'b1;
                    pc_next_s = redirect_pc_I;
                end else begin
                    pc_en_s   = 1'b0;
                end
                state_d = imem_rvalid_I ? REQ : KILL;
            end
            HOLD: begin
                // Redirect masks the handshake so a dropped instruction is never consumed.
                inst_valid_s = !redirect_I;
                if (redirect_I) begin
                    pc_en_s   = 1'b1;
                    pc_next_s = redirect_pc_I;
                    state_d   = REQ;
                end else if (dec_ready_I) begin
                    state_d = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and instruction buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            inst_q    <= {INSTR_W{1'b0}};
            inst_pc_q <= {ADDR_W{1'b0}};
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

    // Every output is forced low while reset is held.
    assign pc_en_O       = rst_n & pc_en_s;
    assign pc_next_O     = rst_n ? pc_next_s : {ADDR_W{1'b0}};
    assign imem_req_O    = rst_n & imem_req_s;
    assign imem_addr_O   = rst_n ? pc_I : {ADDR_W{1'b0}};
    assign inst_valid_O  = rst_n & inst_valid_s;
    assign inst_O        = rst_n ? inst_q : {INSTR_W{1'b0}};
    assign inst_pc_O     = rst_n ? inst_pc_q : {ADDR_W{1'b0}};
    assign fetch_fault_O = rst_n & fault_q;

endmodule

// File: tb/tb_jpc_fetch_ctrl.sv
// Directed bench for jpc_fetch_ctrl: per-cycle vector table plus hand-written
// sequences for backpressure, reset during HOLD and PC wrap-around.
module tb_jpc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        gnt_i, rvalid_i, err_i, rdy_i;
    logic [31:0] rdata_i;

    logic [31:0] pc_m, pc_next_o, addr_o, inst_o, inst_pc_o;
    logic        pc_en_o, req_o, ival_o, fault_o;

    logic [31:0] pc_w, pc_next_w, addr_w, inst_w, inst_pc_w;
    logic        pc_en_w, req_w, ival_w, fault_w;

    int n_chk = 0;
    int n_fail = 0;

    jpc_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pc_I(pc_m), .pc_next_O(pc_next_o), .pc_en_O(pc_en_o),
        .redirect_I(redirect_i), .redirect_pc_I(redirect_pc_i), .imem_req_O(req_o),
        .imem_addr_O(addr_o), .imem_gnt_I(gnt_i), .imem_rvalid_I(rvalid_i),
        .imem_rdata_I(rdata_i), .imem_err_I(err_i), .inst_valid_O(ival_o), .inst_O(inst_o),
        .inst_pc_O(inst_pc_o), .fetch_fault_O(fault_o), .dec_ready_I(rdy_i)
    );

    jpc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .pc_I(pc_w), .pc_next_O(pc_next_w), .pc_en_O(pc_en_w),
        .redirect_I(redirect_i), .redirect_pc_I(redirect_pc_i), .imem_req_O(req_w),
        .imem_addr_O(addr_w), .imem_gnt_I(gnt_i), .imem_rvalid_I(rvalid_i),
        .imem_rdata_I(rdata_i), .imem_err_I(err_i), .inst_valid_O(ival_w), .inst_O(inst_w),
        .inst_pc_O(inst_pc_w), .fetch_fault_O(fault_w), .dec_ready_I(rdy_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External PC registers for both instances.
    always @(posedge clk) begin
        if (pc_en_o) pc_m <= pc_next_o;
        if (pc_en_w) pc_w <= pc_next_w;
    end

    typedef struct {
        logic        rst_n, redir;
        logic [31:0] rpc;
        logic        gnt, rvalid;
        logic [31:0] rdata;
        logic        err, rdy;
        logic        req;
        logic [31:0] addr;
        logic        en;
        logic [31:0] nxt;
        logic        ival;
        logic [31:0] inst, ipc;
        logic        fault;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic r, input logic rd, input logic [31:0] rp, input logic g, input logic rv,
        input logic [31:0] dat, input logic e, input logic dy,
        input logic q, input logic [31:0] a, input logic en, input logic [31:0] nx,
        input logic iv, input logic [31:0] ins, input logic [31:0] ip, input logic f);
        vec_t v;
        v.rst_n = r; v.redir = rd; v.rpc = rp; v.gnt = g; v.rvalid = rv; v.rdata = dat;
        v.err = e; v.rdy = dy; v.req = q; v.addr = a; v.en = en; v.nxt = nx;
        v.ival = iv; v.inst = ins; v.ipc = ip; v.fault = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic rd, input logic [31:0] rp, input logic g,
                          input logic rv, input logic [31:0] dat, input logic e, input logic dy);
        rst_n = r; redirect_i = rd; redirect_pc_i = rp; gnt_i = g;
        rvalid_i = rv; rdata_i = dat; err_i = e; rdy_i = dy;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pc_m = 32'h1234_5678;
        pc_w = 32'h1234_5678;
        // Reset for three cycles, with junk inputs on one of them.
        vecs[0]  = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
        vecs[1]  = mk(1'b0,1'b1,32'h500,1'b1,1'b1,32'h1,1'b1,1'b1, 1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
        vecs[2]  = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
        // BOOT ignores redirect.
        vecs[3]  = mk(1'b1,1'b1,32'h500,1'b0,1'b0,32'h0,1'b0,1'b0, 1'b0,32'h1234_5678,1'b1,32'h0,1'b0,32'h0,32'h0,1'b0);
        // Sequential fetches 0,4,8,C.
        vecs[4]  = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,32'h0,1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
        vecs[5]  = mk(1'b1,1'b0,32'h0,1'b0,1'b1,32'hA000_0001,1'b0,1'b0, 1'b0,32'h0,1'b1,32'h4,1'b0,32'h0,32'h0,1'b0);
        vecs[6]  = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b1, 1'b0,32'h4,1'b0,32'h0,1'b1,32'hA000_0001,32'h0,1'b0);
        vecs[7]  = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,32'h4,1'b0,32'h0,1'b0,32'hA000_0001,32'h0,1'b0);
        vecs[8]  = mk(1'b1,1'b0,32'h0,1'b0,1'b1,32'hA000_0002,1'b0,1'b0, 1'b0,32'h4,1'b1,32'h8,1'b0,32'hA000_0001,32'h0,1'b0);
        vecs[9]  = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b1, 1'b0,32'h8,1'b0,32'h0,1'b1,32'hA000_0002,32'h4,1'b0);
        vecs[10] = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,32'h8,1'b0,32'h0,1'b0,32'hA000_0002,32'h4,1'b0);
        vecs[11] = mk(1'b1,1'b0,32'h0,1'b0,1'b1,32'hA000_0003,1'b0,1'b0, 1'b0,32'h8,1'b1,32'hC,1'b0,32'hA000_0002,32'h4,1'b0);
        vecs[12] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b1, 1'b0,32'hC,1'b0,32'h0,1'b1,32'hA000_0003,32'h8,1'b0);
        vecs[13] = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,32'hC,1'b0,32'h0,1'b0,32'hA000_0003,32'h8,1'b0);
        vecs[14] = mk(1'b1,1'b0,32'h0,1'b0,1'b1,32'hA000_0004,1'b0,1'b0, 1'b0,32'hC,1'b1,32'h10,1'b0,32'hA000_0003,32'h8,1'b0);
        vecs[15] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b1, 1'b0,32'h10,1'b0,32'h0,1'b1,32'hA000_0004,32'hC,1'b0);
        // Redirect in WAIT, wrong-path response two cycles later.
        vecs[16] = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,32'h10,1'b0,32'h0,1'b0,32'hA000_0004,32'hC,1'b0);
        vecs[17] = mk(1'b1,1'b1,32'h100,1'b0,1'b0,32'h0,1'b0,1'b0, 1'b0,32'h10,1'b1,32'h100,1'b0,32'hA000_0004,32'hC,1'b0);
        vecs[18] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b1, 1'b0,32'h100,1'b0,32'h0,1'b0,32'hA000_0004,32'hC,1'b0);
        vecs[19] = mk(1'b1,1'b0,32'h0,1'b0,1'b1,32'hDEAD,1'b0,1'b1, 1'b0,32'h100,1'b0,32'h0,1'b0,32'hA000_0004,32'hC,1'b0);
        vecs[20] = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,32'h100,1'b0,32'h0,1'b0,32'hA000_0004,32'hC,1'b0);
        vecs[21] = mk(1'b1,1'b0,32'h0,1'b0,1'b1,32'hB000_0100,1'b0,1'b0, 1'b0,32'h100,1'b1,32'h104,1'b0,32'hA000_0004,32'hC,1'b0);
        // Redirect in HOLD with decode ready: no transfer.
        vecs[22] = mk(1'b1,1'b1,32'h200,1'b0,1'b0,32'h0,1'b0,1'b1, 1'b0,32'h104,1'b1,32'h200,1'b0,32'hB000_0100,32'h100,1'b0);
        vecs[23] = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,32'h200,1'b0,32'h0,1'b0,32'hB000_0100,32'h100,1'b0);
        vecs[24] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, 1'b0,32'h200,1'b0,32'h0,1'b0,32'hB000_0100,32'h100,1'b0);
        // Redirect coinciding with rvalid in WAIT, then redirects in REQ and KILL.
        vecs[25] = mk(1'b1,1'b1,32'h300,1'b0,1'b1,32'hC0DE,1'b0,1'b0, 1'b0,32'h200,1'b1,32'h300,1'b0,32'hB000_0100,32'h100,1'b0);
        vecs[26] = mk(1'b1,1'b1,32'h400,1'b0,1'b0,32'h0,1'b0,1'b0, 1'b1,32'h300,1'b1,32'h400,1'b0,32'hB000_0100,32'h100,1'b0);
        vecs[27] = mk(1'b1,1'b1,32'h480,1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,32'h400,1'b1,32'h480,1'b0,32'hB000_0100,32'h100,1'b0);
        vecs[28] = mk(1'b1,1'b1,32'h600,1'b0,1'b1,32'hBEEF,1'b0,1'b0, 1'b0,32'h480,1'b1,32'h600,1'b0,32'hB000_0100,32'h100,1'b0);
        vecs[29] = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, 1'b1,32'h600,1'b0,32'h0,1'b0,32'hB000_0100,32'h100,1'b0);
        // Erroring fetch, then a stray rvalid in REQ that must be ignored.
        vecs[30] = mk(1'b1,1'b0,32'h0,1'b0,1'b1,32'h0BAD_0BAD,1'b1,1'b0, 1'b0,32'h600,1'b1,32'h604,1'b0,32'hB000_0100,32'h100,1'b0);
        vecs[31] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b1, 1'b0,32'h604,1'b0,32'h0,1'b1,32'h0BAD_0BAD,32'h600,1'b1);
        vecs[32] = mk(1'b1,1'b0,32'h0,1'b0,1'b1,32'h1111,1'b0,1'b0, 1'b1,32'h604,1'b0,32'h0,1'b0,32'h0BAD_0BAD,32'h600,1'b1);

        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].rst_n, vecs[i].redir, vecs[i].rpc, vecs[i].gnt,
                   vecs[i].rvalid, vecs[i].rdata, vecs[i].err, vecs[i].rdy);
            chk($sformatf("v%0d.req", i),   {31'h0, req_o},   {31'h0, vecs[i].req});
            chk($sformatf("v%0d.addr", i),  addr_o,           vecs[i].addr);
            chk($sformatf("v%0d.pc_en", i), {31'h0, pc_en_o}, {31'h0, vecs[i].en});
            chk($sformatf("v%0d.pc_nx", i), pc_next_o,        vecs[i].nxt);
            chk($sformatf("v%0d.ival", i),  {31'h0, ival_o},  {31'h0, vecs[i].ival});
            chk($sformatf("v%0d.inst", i),  inst_o,           vecs[i].inst);
            chk($sformatf("v%0d.ipc", i),   inst_pc_o,        vecs[i].ipc);
            chk($sformatf("v%0d.fault", i), {31'h0, fault_o}, {31'h0, vecs[i].fault});
            adv();
        end

        // Backpressure after an erroring fetch: buffer stable, no new request.
        set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("bp.req", {31'h0, req_o}, 32'h1);
        chk("bp.addr", addr_o, 32'h604);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hEEEE_0001, 1'b1, 1'b0);
        chk("bp.pc_nx", pc_next_o, 32'h608);
        adv();
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("bp%0d.ival", k),  {31'h0, ival_o},  32'h1);
            chk($sformatf("bp%0d.fault", k), {31'h0, fault_o}, 32'h1);
            chk($sformatf("bp%0d.inst", k),  inst_o,           32'hEEEE_0001);
            chk($sformatf("bp%0d.ipc", k),   inst_pc_o,        32'h604);
            chk($sformatf("bp%0d.req", k),   {31'h0, req_o},   32'h0);
            chk($sformatf("bp%0d.pc_en", k), {31'h0, pc_en_o}, 32'h0);
            adv();
        end

        // Reset asserted mid-HOLD, then BOOT with a cleared buffer.
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst.ival", {31'h0, ival_o}, 32'h0);
        chk("rst.inst", inst_o, 32'h0);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("boot.pc_en", {31'h0, pc_en_o}, 32'h1);
        chk("boot.pc_nx", pc_next_o, 32'h0);
        chk("boot.inst", inst_o, 32'h0);
        chk("boot.ipc", inst_pc_o, 32'h0);
        chk("boot.fault", {31'h0, fault_o}, 32'h0);
        chk("boot.ival", {31'h0, ival_o}, 32'h0);
        chk("wrap.boot_nx", pc_next_w, 32'hFFFF_FFFC);
        adv();

        // PC wrap on the instance booting at 0xFFFFFFFC.
        set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap.req", {31'h0, req_w}, 32'h1);
        chk("wrap.addr0", addr_w, 32'hFFFF_FFFC);
        chk("main.addr0", addr_o, 32'h0);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0005, 1'b0, 1'b0);
        chk("wrap.pc_en", {31'h0, pc_en_w}, 32'h1);
        chk("wrap.pc_nx", pc_next_w, 32'h0);
        chk("main.pc_nx", pc_next_o, 32'h4);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap.ival", {31'h0, ival_w}, 32'h1);
        chk("wrap.ipc", inst_pc_w, 32'hFFFF_FFFC);
        chk("wrap.inst", inst_w, 32'h5);
        chk("wrap.fault", {31'h0, fault_w}, 32'h0);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap.req2", {31'h0, req_w}, 32'h1);
        chk("wrap.addr1", addr_w, 32'h0);
        chk("main.addr1", addr_o, 32'h4);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
